// File: rtl/a1csah_slice_sequencer.sv
// -----------------------------------------------------------------------------
// a1csah_slice_sequencer
//
// Computes an n-bit addition by time-multiplexing one external w-bit adder
// slice. A request is latched, then the slice is driven once per clock,
// least-significant chunk first, with the carry rippled between cycles through
// a register. The assembled sum, carry-out and n-bit group propagate/generate
// are returned over a valid/ready handshake.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   req_valid/req_ready  request handshake; cin, a, b are the request operands
//   add_a/add_b/add_cin  chunk operands and carry driven to the adder slice
//   add_s/add_cout       slice sum and carry-out (combinational response)
//   add_prop/add_gen     slice group propagate / generate
//   resp_valid/resp_ready response handshake
//   s, cout, prop, gen   assembled n-bit result
//
// n must be a multiple of w.
// -----------------------------------------------------------------------------
module a1csah_slice_sequencer #(
    parameter int n = 128,
    parameter int w = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         cin,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic [w-1:0] add_a,
    output logic [w-1:0] add_b,
    output logic         add_cin,
    input  logic [w-1:0] add_s,
    input  logic         add_cout,
    input  logic         add_prop,
    input  logic         add_gen,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [n-1:0] s,
    output logic         cout,
    output logic         prop,
    output logic         gen
);

    localparam int slices = n / w;
    localparam int idx_w  = (slices > 1) ? $clog2(slices) : 1;
    localparam logic [idx_w-1:0] last_idx = idx_w'(slices - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic [idx_w-1:0]   idx_reg;
    logic [n-1:0]       a_reg;
    logic [n-1:0]       b_reg;
    logic               carry_reg;
    logic               prop_acc_reg;
    logic               gen_acc_reg;
    logic               cout_reg;
    logic               prop_reg;
    logic               gen_reg;
    logic               resp_valid_reg;

    logic               accept;
    logic               last_step;
    logic               prop_acc_next;
    logic               gen_acc_next;

    logic [w-1:0]       a_chunk [slices];
    logic [w-1:0]       b_chunk [slices];

    // Held low while reset is asserted so nothing is accepted mid-reset.
    assign req_ready = ~rst & ((state_reg == IDLE) | ((state_reg == DONE) & resp_ready));
    assign accept    = req_valid & req_ready;
    assign last_step = (state_reg == RUN) && (idx_reg == last_idx);

    // Chunks are consumed LSB first, so the accumulated group terms are
    // combined treating the new slice as the more significant group.
    assign prop_acc_next = prop_acc_reg & add_prop;
    assign gen_acc_next  = add_gen | (add_prop & gen_acc_reg);

    // Operand chunk views and per-chunk sum registers. Each sum chunk is only
    // written on the RUN cycle whose index selects it.
    generate
        for (genvar gi = 0; gi < slices; gi++) begin : g_chunk
            logic [w-1:0] s_chunk_reg;

            assign a_chunk[gi] = a_reg[gi*w +: w];
            assign b_chunk[gi] = b_reg[gi*w +: w];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s_chunk_reg <= '0;
                end else if ((state_reg == RUN) && (idx_reg == idx_w'(gi))) begin
                    s_chunk_reg <= add_s;
                end
            end

            assign s[gi*w +: w] = s_chunk_reg;
        end
    endgenerate

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next state and slice drive
    always_comb begin
        state_next = state_reg;
        add_a      = '0;
        add_b      = '0;
        add_cin    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                add_a   = a_chunk[idx_reg];
                add_b   = b_chunk[idx_reg];
                add_cin = carry_reg;
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // A new request in the handshake cycle skips IDLE entirely.
                if (accept) begin
                    state_next = RUN;
                end else if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_reg        <= '0;
            a_reg          <= '0;
            b_reg          <= '0;
            carry_reg      <= 1'b0;
            prop_acc_reg   <= 1'b0;
            gen_acc_reg    <= 1'b0;
            cout_reg       <= 1'b0;
            prop_reg       <= 1'b0;
            gen_reg        <= 1'b0;
            resp_valid_reg <= 1'b0;
        end else begin
            if (accept) begin
                a_reg          <= a;
                b_reg          <= b;
                carry_reg      <= cin;
                idx_reg        <= '0;
                prop_acc_reg   <= 1'b1;
                gen_acc_reg    <= 1'b0;
                resp_valid_reg <= 1'b0;
            end else if (state_reg == RUN) begin
                carry_reg    <= add_cout;
                prop_acc_reg <= prop_acc_next;
                gen_acc_reg  <= gen_acc_next;
                if (last_step) begin
                    idx_reg        <= '0;
                    resp_valid_reg <= 1'b1;
                    cout_reg       <= add_cout;
                    prop_reg       <= prop_acc_next;
                    gen_reg        <= gen_acc_next;
                end else begin
                    idx_reg <= idx_reg + idx_w'(1);
                end
            end else if ((state_reg == DONE) && resp_ready) begin
                resp_valid_reg <= 1'b0;
            end
        end
    end

    assign resp_valid = resp_valid_reg;
    assign cout       = cout_reg;
    assign prop       = prop_reg;
    assign gen        = gen_reg;

endmodule

// File: doc/a1csah_slice_sequencer.md
Name: a1csah_slice_sequencer

Overview:
- Multi-cycle controller that computes an n-bit addition on one shared w-bit adder slice, such as a 32-bit a1csah or cla instance.
- Latches a request, then drives the slice once per cycle, least-significant chunk first, rippling carry between cycles.
- Assembles the n-bit sum, carry-out and group propagate/generate, and returns them over a valid/ready handshake.
- Sits between the operand source (bench reader or host datapath) and the external adder slice.

Parameters:
- n, 128, full operand width.
- w, 32, width of the shared adder slice. n % w == 0 is required. n/w >= 1.
- slices, n/w, derived localparam. Chunk counter width is clog2(slices), minimum 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- cin  in  1  request carry-in.
- a  in  n  request operand A.
- b  in  n  request operand B.
- add_a  out  w  chunk of A driven to the slice.
- add_b  out  w  chunk of B driven to the slice.
- add_cin  out  1  carry driven to the slice.
- add_s  in  w  slice sum (combinational response).
- add_cout  in  1  slice carry-out.
- add_prop  in  1  slice group propagate.
- add_gen  in  1  slice group generate.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer takes the result.
- s  out  n  assembled sum.
- cout  out  1  final carry-out.
- prop  out  1  n-bit group propagate.
- gen  out  1  n-bit group generate.

Behaviour:
- FSM states: IDLE, RUN, DONE.
- Reset (async, any state): state=IDLE; idx=0; operand regs=0; carry=0; s=0; cout=0; prop=0; gen=0; resp_valid=0; add_a/add_b/add_cin=0. req_ready=1 once rst is low.
- req_ready = (state==IDLE) | (state==DONE & resp_ready). This is combinational.
- Accept: on an edge with req_valid & req_ready:
  - latch a, b;
  - carry<=cin; idx<=0; prop_acc<=1; gen_acc<=0;
  - state<=RUN; resp_valid<=0.
- RUN, combinational outputs: add_a=a_reg[idx*w +: w]; add_b=b_reg[idx*w +: w]; add_cin=carry.
- RUN, each edge:
  - s[idx*w +: w]<=add_s; carry<=add_cout;
  - prop_acc<=prop_acc & add_prop;
  - gen_acc<=add_gen | (add_prop & gen_acc);
  - idx<=idx+1.
- RUN, last edge (idx==slices-1): state<=DONE; resp_valid<=1; cout<=add_cout; prop<=final prop_acc; gen<=final gen_acc. Idx wraps to 0.
- Latency: resp_valid rises on the edge exactly `slices` clocks after the accept edge. For defaults that is 4 clocks.
- DONE:
  - s, cout, prop and gen are held stable while resp_valid=1 and resp_ready=0.
  - On resp_ready with no new request: resp_valid<=0, state<=IDLE. s and cout hold their last value.
  - On resp_ready and req_valid in the same cycle: the handshake completes and the new request is accepted on that same edge, so there is no bubble.
- In IDLE and DONE, add_a, add_b and add_cin are driven 0.
- req_valid is ignored while in RUN. Upstream must hold the request until req_ready.
- slices==1: RUN lasts one cycle and the same rules apply.
- The slice response must settle within one clk period. No timing check is made.

Test Plan:
- Reset mid-RUN: assert rst at idx=2 -> outputs zero immediately, state IDLE, req_ready=1 after release. The next request computes correctly.
- Carry ripple, n=128/w=32: a=all ones, b=1, cin=0 -> s=0, cout=1, prop=0, gen=1. resp_valid goes high 4 clocks after accept. add_cin reads 0,1,1,1 across the four RUN cycles.
- Pure propagate: a=0xAAAA…AA, b=0x5555…55.
  - cin=0 -> s=all ones, cout=0, prop=1, gen=0.
  - cin=1 -> s=0, cout=1, prop=1.
- Backpressure: hold resp_ready=0 for 10 cycles after resp_valid -> s/cout/prop/gen stable, req_ready=0. Then raise resp_ready and req_valid together -> new request accepted on that edge, and the next resp_valid comes 4 clocks later.
- Small values: a=5, b=7, cin=1 -> s=13, cout=0, prop=0, gen=0. Only slice 0 is non-zero.
- Random regression: 30000 random {a, b, cin} vectors checked against the reference adder model (s, cout, prop, gen) -> zero mismatches. Each vector is logged with its cycle count, which must equal slices.
